led_ring_decoder: RTL and testbench

Receive-side tracker for the 8-bit rotating one-hot LED ring pattern driven by the ring shifter. It samples the ring bus every clock, locks onto a legal one-hot pattern, and reports the lit position. It also reports single-step advances, completed revolutions and loss-of-lock events. It sits on the same clock as the shifter and is used as an on-chip checker and position source for downstream display logic.

---
 rtl/led_ring_if.sv | 15 +
 rtl/led_ring_decoder.sv | 100 ++++++++++
 tb/tb_led_ring_decoder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/led_ring_if.sv
// Ring-bus observation interface: the observed LED pattern plus the decoder's reported status.
interface led_ring_if #(
  parameter int REV_W = 8,
  parameter int ERR_W = 8
);
  logic [7:0]       led;
  logic [2:0]       pos;
  logic             valid;
  logic             step;
  logic [REV_W-1:0] rev_cnt;
  logic [ERR_W-1:0] err_cnt;

  modport master (output led, input pos, valid, step, rev_cnt, err_cnt);
  modport slave  (input led, output pos, valid, step, rev_cnt, err_cnt);
endinterface

// File: rtl/led_ring_decoder.sv
// Tracks a rotating one-hot LED ring: locks on a one-hot sample, then reports position,
// advance pulses, completed revolutions and loss-of-lock events.
//   state | meaning
//   HUNT  | waiting for a one-hot sample to lock onto
//   LOCK  | following the ring; anything but hold or rotate-left drops lock
module led_ring_decoder #(
  parameter int REV_W = 8,
  parameter int ERR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  led_ring_if.slave    bus
);
  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic [2:0]       pos_q, pos_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             led_onehot;
  logic [2:0]       led_idx;
  logic [7:0]       prev_rotl;

  always_comb begin
    led_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.led[i]) led_idx = 3'(i);
    end
  end

  assign led_onehot = (bus.led != 8'h00) && ((bus.led & (bus.led - 8'h01)) == 8'h00);
  assign prev_rotl  = {prev_q[6:0], prev_q[7]};

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    pos_d     = pos_q;
    valid_d   = valid_q;
    step_d    = 1'b0;
    rev_cnt_d = rev_cnt_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      HUNT: begin
        valid_d = 1'b0;
        if (led_onehot) begin
          prev_d  = bus.led;
          pos_d   = led_idx;
          valid_d = 1'b1;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (bus.led == prev_q) begin
          valid_d = 1'b1;
        end else if (bus.led == prev_rotl) begin
          step_d = 1'b1;
          pos_d  = pos_q + 3'd1;
          prev_d = bus.led;
          if (prev_q == 8'h80) rev_cnt_d = rev_cnt_q + REV_W'(1);
        end else begin
          // the offending sample is discarded; relock is judged on the next edge
          valid_d = 1'b0;
          state_d = HUNT;
          if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      prev_q    <= 8'h00;
      pos_q     <= 3'd0;
      valid_q   <= 1'b0;
      step_q    <= 1'b0;
      rev_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pos_q     <= pos_d;
      valid_q   <= valid_d;
      step_q    <= step_d;
      rev_cnt_q <= rev_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.pos     = pos_q;
  assign bus.valid   = valid_q;
  assign bus.step    = step_q;
  assign bus.rev_cnt = rev_cnt_q;
  assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_led_ring_decoder.sv
// Bench for led_ring_decoder: directed table, hand-written corner sequences, and random stimulus vs a pattern-level model.
module tb_led_ring_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] led_drv = 8'h00;

  int checks = 0;
  int errors = 0;

  led_ring_if #(.REV_W(8), .ERR_W(8)) bus1 ();
  led_ring_if #(.REV_W(8), .ERR_W(2)) bus2 ();
  assign bus1.led = led_drv;
  assign bus2.led = led_drv;

  led_ring_decoder #(.REV_W(8), .ERR_W(8)) u_dut  (.clk(clk), .rst(rst), .bus(bus1));
  led_ring_decoder #(.REV_W(8), .ERR_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    int         pos;
    int         valid;
    int         step;
    int         rev;
    int         err;
  } vec_t;

  vec_t vecs[$];

  // pattern-level reference model
  int        m_locked, m_steps, m_revs, m_errs;
  logic [7:0] m_cur;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int p, input int v, input int s,
                           input int r, input int e);
    check({name, ".pos"},   int'(bus1.pos),     p);
    check({name, ".valid"}, int'(bus1.valid),   v);
    check({name, ".step"},  int'(bus1.step),    s);
    check({name, ".rev"},   int'(bus1.rev_cnt), r);
    check({name, ".err"},   int'(bus1.err_cnt), e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    led_drv = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply(input logic [7:0] v);
    @(negedge clk);
    led_drv = v;
    @(posedge clk);
    #1;
  endtask

  function automatic int bit_index(input logic [7:0] p);
    for (int i = 0; i < 8; i++) if (p == 8'(1 << i)) return i;
    return 0;
  endfunction

  function automatic int ones(input logic [7:0] p);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(p[i]);
    return n;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_steps = 0; m_revs = 0; m_errs = 0; m_cur = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] v);
    int nxt;
    m_steps = 0;
    nxt = (m_cur == 8'h80) ? 1 : int'(m_cur) * 2;
    if (!m_locked) begin
      if (ones(v) == 1) begin
        m_locked = 1;
        m_cur = v;
      end
    end else if (v == m_cur) begin
      m_steps = 0;
    end else if (int'(v) == nxt) begin
      m_steps = 1;
      if (m_cur == 8'h80) m_revs++;
      m_cur = v;
    end else begin
      m_locked = 0;
      m_errs++;
    end
  endtask

  function automatic vec_t mk(input logic [7:0] l, input int p, input int v, input int s,
                              input int r, input int e);
    vec_t t;
    t.led = l; t.pos = p; t.valid = v; t.step = s; t.rev = r; t.err = e;
    return t;
  endfunction

  initial begin
    logic [7:0] stim;
    int         sel;

    // lock and hold, full revolution, skip errors, reverse step then illegal samples in HUNT
    vecs.push_back(mk(8'h01, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'h01, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'h01, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'h01, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'h02, 1, 1, 1, 0, 0));
    vecs.push_back(mk(8'h04, 2, 1, 1, 0, 0));
    vecs.push_back(mk(8'h08, 3, 1, 1, 0, 0));
    vecs.push_back(mk(8'h10, 4, 1, 1, 0, 0));
    vecs.push_back(mk(8'h20, 5, 1, 1, 0, 0));
    vecs.push_back(mk(8'h40, 6, 1, 1, 0, 0));
    vecs.push_back(mk(8'h80, 7, 1, 1, 0, 0));
    vecs.push_back(mk(8'h01, 0, 1, 1, 1, 0));
    vecs.push_back(mk(8'h04, 0, 0, 0, 1, 1));
    vecs.push_back(mk(8'h04, 2, 1, 0, 1, 1));
    vecs.push_back(mk(8'h10, 2, 0, 0, 1, 2));
    vecs.push_back(mk(8'h10, 4, 1, 0, 1, 2));
    vecs.push_back(mk(8'h08, 4, 0, 0, 1, 3));
    vecs.push_back(mk(8'h18, 4, 0, 0, 1, 3));
    vecs.push_back(mk(8'h00, 4, 0, 0, 1, 3));
    vecs.push_back(mk(8'h08, 3, 1, 0, 1, 3));
    vecs.push_back(mk(8'h10, 4, 1, 1, 1, 3));

    do_reset();
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].led);
      check_all($sformatf("vec%0d", i), vecs[i].pos, vecs[i].valid, vecs[i].step,
                vecs[i].rev, vecs[i].err);
    end

    // error counter saturation on the narrow instance
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(8'h01);
      check($sformatf("sat_lock%0d", k), int'(bus2.valid), 1);
      apply(8'h04);
      check($sformatf("sat_err%0d", k), int'(bus2.err_cnt), (k + 1 > 3) ? 3 : k + 1);
      check($sformatf("sat_valid%0d", k), int'(bus2.valid), 0);
    end
    apply(8'h04);
    check("sat_relock_pos", int'(bus2.pos), 2);
    check("sat_relock_valid", int'(bus2.valid), 1);

    // asynchronous reset mid-rotation
    do_reset();
    apply(8'h01);
    for (int k = 0; k < 21; k++) apply(8'(1 << ((k + 1) % 8)));
    check_all("pre_async", 5, 1, 1, 2, 0);
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    apply(8'h20);
    check_all("post_async", 5, 1, 0, 0, 0);

    // random stimulus against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 99));
      if (m_locked != 0 && sel < 60)      stim = (m_cur == 8'h80) ? 8'h01 : (m_cur << 1);
      else if (m_locked != 0 && sel < 75) stim = m_cur;
      else if (sel < 88)                  stim = 8'(1 << $urandom_range(0, 7));
      else                                stim = 8'($urandom_range(0, 255));
      apply(stim);
      model_step(stim);
      check_all($sformatf("rnd%0d", n), bit_index(m_cur), m_locked, m_steps,
                m_revs % 256, (m_errs > 255) ? 255 : m_errs);
      check($sformatf("rnd%0d.err2", n), int'(bus2.err_cnt), (m_errs > 3) ? 3 : m_errs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
